// File: rtl/alu_vector_checker.sv
// ROM-driven test vector player for ALU-style datapath units: fetches packed vectors,
// drives the unit under test, checks result and flags, and keeps per-opcode counters.
module alu_vector_checker #(
   parameter int OP_W        = 8,
   parameter int DATA_W      = 16,
   parameter int FLAG_W      = 4,
   parameter int NUM_TESTS   = 67,
   parameter int DUT_LATENCY = 0,
   parameter int CNT_W       = 8,
   parameter int ADDR_W      = 8
) (
   input  logic                                        i_clk,
   input  logic                                        i_rst_n,
   input  logic                                        i_start,
   input  logic                                        i_stop_on_fail,
   output logic [ADDR_W-1:0]                           o_vec_addr,
   input  logic [OP_W+3*DATA_W+2*FLAG_W-1:0]           i_vec_data,
   output logic [OP_W-1:0]                             o_dut_op,
   output logic [DATA_W-1:0]                           o_dut_x,
   output logic [DATA_W-1:0]                           o_dut_y,
   output logic [FLAG_W-1:0]                           o_dut_f,
   input  logic [DATA_W-1:0]                           i_dut_o,
   input  logic [FLAG_W-1:0]                           i_dut_fres,
   output logic                                        o_busy,
   output logic                                        o_done,
   output logic                                        o_pass,
   output logic [15:0]                                 o_fail_count,
   output logic [ADDR_W-1:0]                           o_first_fail_idx,
   input  logic [OP_W-1:0]                             i_rd_op,
   output logic [CNT_W-1:0]                            o_rd_err,
   output logic [CNT_W-1:0]                            o_rd_total
);
   localparam int DEPTH    = 1 << OP_W;
   localparam int OEXP_LSB = FLAG_W;
   localparam int F_LSB    = FLAG_W + DATA_W;
   localparam int Y_LSB    = F_LSB + FLAG_W;
   localparam int X_LSB    = Y_LSB + DATA_W;
   localparam int OP_LSB   = X_LSB + DATA_W;
   localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'((NUM_TESTS > 0) ? NUM_TESTS - 1 : 0);
   localparam logic [3:0]        WAIT_INIT = 4'((DUT_LATENCY > 0) ? DUT_LATENCY - 1 : 0);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_FETCH, S_LOAD, S_WAIT, S_CHECK, S_DONE
   } state_t;

   state_t              r_state;
   logic                r_stop_on_fail;
   logic [ADDR_W-1:0]   r_idx;
   logic [OP_W-1:0]     r_clr_idx;
   logic [3:0]          r_wait_cnt;
   logic [OP_W-1:0]     r_op;
   logic [DATA_W-1:0]   r_x, r_y, r_o_exp;
   logic [FLAG_W-1:0]   r_f, r_f_exp;
   logic                r_busy, r_done, r_pass;
   logic [15:0]         r_fail_count;
   logic [ADDR_W-1:0]   r_first_fail_idx;
   logic [CNT_W-1:0]    r_err_cur, r_total_cur;
   logic [CNT_W-1:0]    r_rd_err, r_rd_total;

   logic [CNT_W-1:0]    r_err_mem   [DEPTH];
   logic [CNT_W-1:0]    r_total_mem [DEPTH];

   logic [OP_W-1:0]     w_vec_op;
   logic                w_fail, w_last, w_clearing, w_mem_we;
   logic [OP_W-1:0]     w_mem_addr;
   logic [CNT_W-1:0]    w_err_wdata, w_total_wdata;
   logic [15:0]         w_fail_count_next;

   assign w_vec_op   = i_vec_data[OP_LSB +: OP_W];
   assign w_fail     = (i_dut_o != r_o_exp) || (i_dut_fres != r_f_exp);
   assign w_last     = (r_idx == LAST_IDX) || (w_fail && r_stop_on_fail);
   assign w_clearing = (r_state == S_CLEAR);
   assign w_mem_we   = i_rst_n && (w_clearing || (r_state == S_CHECK));
   assign w_mem_addr = w_clearing ? r_clr_idx : r_op;

   // Counters saturate at all-ones: hold instead of incrementing
   assign w_err_wdata   = w_clearing ? '0 :
                          (w_fail && (r_err_cur != '1)) ? r_err_cur + CNT_W'(1) : r_err_cur;
   assign w_total_wdata = w_clearing ? '0 :
                          (r_total_cur != '1) ? r_total_cur + CNT_W'(1) : r_total_cur;
   assign w_fail_count_next = (w_fail && (r_fail_count != 16'hFFFF)) ?
                              r_fail_count + 16'd1 : r_fail_count;

   assign o_vec_addr       = r_idx;
   assign o_dut_op         = r_op;
   assign o_dut_x          = r_x;
   assign o_dut_y          = r_y;
   assign o_dut_f          = r_f;
   assign o_busy           = r_busy;
   assign o_done           = r_done;
   assign o_pass           = r_pass;
   assign o_fail_count     = r_fail_count;
   assign o_first_fail_idx = r_first_fail_idx;
   assign o_rd_err         = r_rd_err;
   assign o_rd_total       = r_rd_total;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state          <= S_IDLE;
         r_stop_on_fail   <= 1'b0;
         r_idx            <= '0;
         r_clr_idx        <= '0;
         r_wait_cnt       <= '0;
         r_op             <= '0;
         r_x              <= '0;
         r_y              <= '0;
         r_f              <= '0;
         r_o_exp          <= '0;
         r_f_exp          <= '0;
         r_busy           <= 1'b0;
         r_done           <= 1'b0;
         r_pass           <= 1'b0;
         r_fail_count     <= '0;
         r_first_fail_idx <= '1;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (i_start) begin
                  r_state          <= S_CLEAR;
                  r_stop_on_fail   <= i_stop_on_fail;
                  r_fail_count     <= '0;
                  r_first_fail_idx <= '1;
                  r_done           <= 1'b0;
                  r_pass           <= 1'b0;
                  r_busy           <= 1'b1;
                  r_clr_idx        <= '0;
               end
            end
            S_CLEAR: begin
               r_clr_idx <= r_clr_idx + OP_W'(1);
               if (r_clr_idx == '1) begin
                  r_idx <= '0;
                  if (NUM_TESTS == 0) begin
                     r_state <= S_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_pass  <= 1'b1;
                  end else begin
                     r_state <= S_FETCH;
                  end
               end
            end
            S_FETCH: r_state <= S_LOAD;
            S_LOAD: begin
               r_op       <= w_vec_op;
               r_x        <= i_vec_data[X_LSB +: DATA_W];
               r_y        <= i_vec_data[Y_LSB +: DATA_W];
               r_f        <= i_vec_data[F_LSB +: FLAG_W];
               r_o_exp    <= i_vec_data[OEXP_LSB +: DATA_W];
               r_f_exp    <= i_vec_data[0 +: FLAG_W];
               r_wait_cnt <= WAIT_INIT;
               r_state    <= (DUT_LATENCY == 0) ? S_CHECK : S_WAIT;
            end
            S_WAIT: begin
               if (r_wait_cnt == '0) r_state <= S_CHECK;
               else                  r_wait_cnt <= r_wait_cnt - 4'd1;
            end
            S_CHECK: begin
               r_fail_count <= w_fail_count_next;
               // fail_count saturates, so zero here means no earlier failure
               if (w_fail && (r_fail_count == '0)) r_first_fail_idx <= r_idx;
               if (w_last) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_pass  <= (w_fail_count_next == '0);
               end else begin
                  r_idx   <= r_idx + ADDR_W'(1);
                  r_state <= S_FETCH;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Counter RAM: one write port shared by clear and update, operand read staged in LOAD
   always_ff @(posedge i_clk) begin
      if (w_mem_we) begin
         r_err_mem[w_mem_addr]   <= w_err_wdata;
         r_total_mem[w_mem_addr] <= w_total_wdata;
      end
      if (r_state == S_LOAD) begin
         r_err_cur   <= r_err_mem[w_vec_op];
         r_total_cur <= r_total_mem[w_vec_op];
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_rd_err   <= '0;
         r_rd_total <= '0;
      end else begin
         r_rd_err   <= r_err_mem[i_rd_op];
         r_rd_total <= r_total_mem[i_rd_op];
      end
   end
endmodule

// File: doc/alu_vector_checker.md
# alu_vector_checker

Synthesizable, parametrised self-checking vector player for the CPU ALU and similar combinational or pipelined datapath units. It fetches packed test vectors from a synchronous ROM, drives the DUT operand/flag inputs, waits a configurable latency, compares result and flags, and keeps per-opcode saturating error/total counters. It sits beside the ALU in on-FPGA bring-up builds and in simulation. Pass/fail and per-op statistics are available without a simulator.

## Interface
Parameters:
- `OP_W`, 8: opcode width; one counter pair per opcode, 2^OP_W entries.
- `DATA_W`, 16: operand and result width.
- `FLAG_W`, 4: flag width.
- `NUM_TESTS`, 67: number of vectors in the ROM; 0 is legal.
- `DUT_LATENCY`, 0: cycles from driving the DUT inputs to a valid DUT output; range 0–15.
- `CNT_W`, 8: width of each per-op counter.
- `ADDR_W`, 8: ROM address width; must satisfy 2^ADDR_W ≥ NUM_TESTS.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset. One clock; reset is synchronous and active-low.
- `start`, in, 1: one-cycle pulse that begins a run.
- `stop_on_fail`, in, 1: sampled at start. When 1, the run ends after the first failing vector.
- `vec_addr`, out, ADDR_W: ROM address.
- `vec_data`, in, OP_W+2·DATA_W+FLAG_W+DATA_W+FLAG_W: ROM data, valid one cycle after the address. Packing, MSB to LSB: {op, x, y, f, o_exp, f_exp}.
- `dut_op`, out, OP_W: DUT opcode.
- `dut_x`, out, DATA_W: DUT first operand.
- `dut_y`, out, DATA_W: DUT second operand.
- `dut_f`, out, FLAG_W: DUT input flags.
- `dut_o`, in, DATA_W: DUT result.
- `dut_fres`, in, FLAG_W: DUT result flags.
- `busy`, out, 1: run in progress.
- `done`, out, 1: level signal, high from the end of a run until the next start.
- `pass`, out, 1: valid when done; 1 if zero vectors failed.
- `fail_count`, out, 16: total failing vectors in the run; saturating.
- `first_fail_idx`, out, ADDR_W: index of the first failing vector; all-ones if none failed.
- `rd_op`, in, OP_W: counter readback select.
- `rd_err`, out, CNT_W: error count for `rd_op`, registered, one-cycle latency.
- `rd_total`, out, CNT_W: total count for `rd_op`, registered, one-cycle latency.

## Operation
FSM states: IDLE, CLEAR, FETCH, LOAD, WAIT, CHECK, DONE.
- **IDLE**: waits for `start`. On `start`, go to CLEAR; latch `stop_on_fail`; zero `fail_count`; set `first_fail_idx` to all-ones; deassert `done`.
- **CLEAR**: zero one counter entry per cycle, 0 .. 2^OP_W−1. Then go to FETCH with index 0. If NUM_TESTS=0, go directly to DONE.
- **FETCH**: drive `vec_addr`=index.
- **LOAD**: register `vec_data`. Drive the `dut_*` outputs from the registered fields; they hold until the next LOAD. If DUT_LATENCY=0, go to CHECK; otherwise go to WAIT.
- **WAIT**: count DUT_LATENCY cycles, then go to CHECK.
- **CHECK**: fail = (`dut_o`≠o_exp) OR (`dut_fres`≠f_exp).
  - total[op] += 1.
  - If fail: err[op] += 1 and `fail_count` += 1. If this is the first failure, record the index in `first_fail_idx`.
  - All counters saturate at their maximum and never wrap.
  - Next state: DONE if index = NUM_TESTS−1, or if fail and `stop_on_fail` is set; otherwise index += 1 and go to FETCH.
- **DONE**: `done`=1, `pass` = (`fail_count`==0). A new `start` re-enters CLEAR.
- Readback is allowed in any state. During CLEAR or CHECK, `rd_*` may show the pre- or post-update value.
- `start` outside IDLE/DONE is ignored.

## Timing
- Reset values: all outputs 0 except `first_fail_idx`, which is all-ones. State is IDLE. Counter RAM contents are undefined after reset and are zeroed by CLEAR.
- `rst_n` low in any state returns the block to IDLE on the next edge. `busy`/`done` drop and the run is abandoned.
- `busy`=1 from the cycle after `start` until DONE is entered.
- Per-vector cost: 3 + DUT_LATENCY cycles.
- Run length: 2^OP_W + NUM_TESTS·(3+DUT_LATENCY) cycles, then `done` is asserted.
- DUT inputs change only on the LOAD edge; DUT outputs are sampled only in CHECK.

## Test plan
- **All-pass run**: golden ALU, 67-vector ROM, latency 0, start → `done` after 256+201 cycles; `pass`=1; `fail_count`=0; `first_fail_idx`=0xFF; `rd_total` for the ADD opcode equals its vector count.
- **Injected fault**: corrupt o_exp of vector 5 (op=SUB) → `pass`=0; `fail_count`=1; `first_fail_idx`=5; err[SUB]=1; the other err entries are 0.
- **stop_on_fail**: faults at vectors 3 and 9, `stop_on_fail`=1 → `done` after 256+4·3 cycles; `fail_count`=1; total[op of vector 9]=0.
- **Latency**: DUT_LATENCY=2 with the golden DUT registered twice → all pass; run takes 256+67·5 cycles. The same DUT with DUT_LATENCY=0 → failures.
- **Saturation**: CNT_W=2, five failing vectors with the same op → err=3 and total=3 (both saturated); no wrap.
- **Reset mid-run**: `rst_n`=0 during WAIT → next cycle IDLE, all outputs at reset values. A new start gives a clean run with counters re-zeroed.
